led_frame_tx: RTL and testbench

//   Drives the WS2812-style one-wire LED chain for the Pong display.
//   - Sequences the 24-bit GRB colour shift registers: asserts LoadRegister once per frame, then RotateRegisterLeft once per bit.
//   - Picks, per LED index, which colour stream (player 1/2/3, ball or black) is sent.
//   - Encodes each bit as a timed high/low pulse on DataOut, then holds the line low for the latch/reset gap.

---
 rtl/led_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_led_frame_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_tx.sv
// led_frame_tx: WS2812-style one-wire frame generator for the Pong LED chain.
// Sequences colour register load/rotate and times each bit on DataOut.
module led_frame_tx #(
  parameter int NUM_LEDS = 64,
  parameter int IDX_W    = 6,
  parameter int BIT_CYC  = 63,
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int RES_CYC  = 2750
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] pos_p1,
  input  logic [IDX_W-1:0] pos_p2,
  input  logic [IDX_W-1:0] pos_p3,
  input  logic [IDX_W-1:0] pos_ball,
  input  logic             CurrentBit_1,
  input  logic             CurrentBit_2,
  input  logic             CurrentBit_3,
  input  logic             CurrentBit_b,
  output logic             LoadRegister,
  output logic             RotateRegisterLeft,
  output logic             DataOut,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_MAX = (RES_CYC > BIT_CYC) ? RES_CYC : BIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_CYC - 1);
  localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYC);
  localparam logic [IDX_W-1:0] LED_LAST = IDX_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_LATCH
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] led_q, led_d;
  logic             bit_q, bit_d;
  logic [IDX_W-1:0] p1_q, p1_d;
  logic [IDX_W-1:0] p2_q, p2_d;
  logic [IDX_W-1:0] p3_q, p3_d;
  logic [IDX_W-1:0] pb_q, pb_d;
  logic             sel_bit;

  // Ball wins over paddles; an index nobody occupies stays dark.
  always_comb begin
    sel_bit = 1'b0;
    if (led_q == pb_q) begin
      sel_bit = CurrentBit_b;
    end else if (led_q == p1_q) begin
      sel_bit = CurrentBit_1;
    end else if (led_q == p2_q) begin
      sel_bit = CurrentBit_2;
    end else if (led_q == p3_q) begin
      sel_bit = CurrentBit_3;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    led_d     = led_q;
    bit_d     = bit_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    pb_d      = pb_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          p1_d    = pos_p1;
          p2_d    = pos_p2;
          p3_d    = pos_p3;
          pb_d    = pos_ball;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        led_d     = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (cnt_q == '0) begin
          bit_d = sel_bit;
        end
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (led_q == LED_LAST) begin
              state_d = S_LATCH;
            end else begin
              led_d = led_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == RES_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      led_q     <= '0;
      bit_q     <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      pb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      led_q     <= led_d;
      bit_q     <= bit_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      pb_q      <= pb_d;
    end
  end

  // On cnt 0 bit_q is still stale, but both high times exceed zero.
  assign LoadRegister       = (state_q == S_LOAD);
  assign RotateRegisterLeft = (state_q == S_SEND) && (cnt_q == BIT_LAST);
  assign DataOut            = (state_q == S_SEND) &&
                              (cnt_q < (bit_q ? T1H : T0H));
  assign busy               = (state_q != S_IDLE);
  assign frame_done         = (state_q == S_LATCH) && (cnt_q == RES_LAST);

endmodule

// File: tb/tb_led_frame_tx.sv
// tb_led_frame_tx: directed bench with a frame-level reference model
// and behavioural GRB colour shift registers.
module tb_led_frame_tx;

  localparam int NL   = 4;
  localparam int IW   = 6;
  localparam int BC   = 10;
  localparam int T0   = 3;
  localparam int T1   = 6;
  localparam int RC   = 20;
  localparam int LEDC = 24 * BC;
  localparam int SLEN = NL * LEDC;
  localparam int FLEN = 1 + SLEN + RC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] pos_p1 = 6'd9;
  logic [IW-1:0] pos_p2 = 6'd9;
  logic [IW-1:0] pos_p3 = 6'd9;
  logic [IW-1:0] pos_ball = 6'd9;
  logic          cb1, cb2, cb3, cbb;
  logic          ld, rot, dout, busy, fdone;

  logic [23:0] col1 = 24'h0;
  logic [23:0] col2 = 24'h0;
  logic [23:0] col3 = 24'h0;
  logic [23:0] colb = 24'h0;
  logic [23:0] r1 = 24'h0;
  logic [23:0] r2 = 24'h0;
  logic [23:0] r3 = 24'h0;
  logic [23:0] rb = 24'h0;

  always #5 clk = ~clk;

  led_frame_tx #(
    .NUM_LEDS(NL), .IDX_W(IW), .BIT_CYC(BC),
    .T0H_CYC(T0), .T1H_CYC(T1), .RES_CYC(RC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pos_p1(pos_p1), .pos_p2(pos_p2),
    .pos_p3(pos_p3), .pos_ball(pos_ball),
    .CurrentBit_1(cb1), .CurrentBit_2(cb2),
    .CurrentBit_3(cb3), .CurrentBit_b(cbb),
    .LoadRegister(ld), .RotateRegisterLeft(rot),
    .DataOut(dout), .busy(busy), .frame_done(fdone)
  );

  assign cb1 = r1[23];
  assign cb2 = r2[23];
  assign cb3 = r3[23];
  assign cbb = rb[23];

  always @(posedge clk) begin
    if (ld) begin
      r1 <= col1; r2 <= col2; r3 <= col3; rb <= colb;
    end else if (rot) begin
      r1 <= {r1[22:0], r1[23]};
      r2 <= {r2[22:0], r2[23]};
      r3 <= {r3[22:0], r3[23]};
      rb <= {rb[22:0], rb[23]};
    end
  end

  // Reference: a frame is FLEN cycles starting the cycle after start
  // is accepted; each LED word is chosen once at acceptance.
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [23:0] m_word [NL];

  function automatic logic [23:0] pick(int i);
    if (int'(pos_ball) == i) return colb;
    if (int'(pos_p1) == i) return col1;
    if (int'(pos_p2) == i) return col2;
    if (int'(pos_p3) == i) return col3;
    return 24'h0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_t   <= 0;
        for (int i = 0; i < NL; i++) m_word[i] <= pick(i);
      end
    end else if (m_t == FLEN - 1) begin
      m_act <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  int   vecs = 0;
  int   errs = 0;
  bit   chk_en = 1'b0;
  logic [4:0] exp_v;

  function automatic logic [4:0] expect_at(int t);
    int s, led, b, c;
    logic e_rot, e_do;
    e_rot = 1'b0;
    e_do  = 1'b0;
    if (t >= 1 && t <= SLEN) begin
      s   = t - 1;
      led = s / LEDC;
      b   = (s / BC) % 24;
      c   = s % BC;
      e_rot = (c == BC - 1);
      e_do  = (c < (m_word[led][23-b] ? T1 : T0));
    end
    return {t == 0, e_rot, e_do, 1'b1, t == FLEN - 1};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = m_act ? expect_at(m_t) : 5'b0;
      vecs++;
      if ({ld, rot, dout, busy, fdone} !== exp_v) begin
        errs++;
        $display("FAIL cycle_outputs t=%0d act=%0d ld/rot/do/busy/fd got %b want %b",
                 m_t, m_act, {ld, rot, dout, busy, fdone}, exp_v);
      end
    end
  end

  // Measurement of DUT activity, checked against literals below.
  int abs_c = 0;
  int mon_t = -1;
  int n_ld = 0;
  int n_rot = 0;
  int n_fd = 0;
  int fd_t = -1;
  int last_fd = -100;
  int gap = -1;
  int sig = 0;
  int sig_last = 0;
  int hi [NL][24];

  always @(negedge clk) begin
    abs_c++;
    if (ld) begin
      n_ld++;
      mon_t = 0;
      gap   = abs_c - last_fd;
      n_rot = 0;
      sig   = 0;
      for (int i = 0; i < NL; i++)
        for (int j = 0; j < 24; j++) hi[i][j] = 0;
    end else if (mon_t >= 0) begin
      mon_t++;
    end
    if (rot) n_rot++;
    if (dout && mon_t >= 1 && mon_t <= SLEN) begin
      hi[(mon_t-1)/LEDC][((mon_t-1)/BC)%24]++;
      sig += mon_t;
    end
    if (fdone) begin
      n_fd++;
      fd_t     = mon_t;
      last_fd  = abs_c;
      sig_last = sig;
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic wait_ld(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!ld && k < 2 * FLEN) begin
      @(negedge clk);
      k++;
    end
    if (!ld) chk({nm, "_ld_timeout"}, 0, 1);
    #1;
  endtask

  task automatic wait_fd(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!fdone && k < 2 * FLEN) begin
      @(negedge clk);
      k++;
    end
    if (!fdone) chk({nm, "_fd_timeout"}, 0, 1);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  function automatic int led_sum(int i);
    int s;
    s = 0;
    for (int j = 0; j < 24; j++) s += hi[i][j];
    return s;
  endfunction

  int base_ld, base_fd, s1, s2, s3;

  initial begin
    // 1: reset and idle
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_outputs", int'({ld, rot, dout, busy, fdone}), 0);
    chk("idle_no_load", n_ld, 0);

    // 2: ball only at LED2
    colb = 24'hFF0000; col1 = 24'hA5A5A5;
    col2 = 24'h5A5A5A; col3 = 24'hFFFFFF;
    pos_ball = 6'd2;
    base_ld = n_ld;
    pulse_start();
    wait_ld("t2");
    wait_fd("t2");
    chk("t2_loads", n_ld - base_ld, 1);
    chk("t2_rotations", n_rot, 96);
    chk("t2_fd_offset", fd_t, 980);
    chk("t2_led0_high", led_sum(0), 72);
    chk("t2_led1_high", led_sum(1), 72);
    chk("t2_led3_high", led_sum(3), 72);
    chk("t2_led2_high", led_sum(2), 96);
    chk("t2_led2_b7", hi[2][7], 6);
    chk("t2_led2_b8", hi[2][8], 3);

    // 3: ball overrides p1 on the same LED
    col1 = 24'h0000FF; colb = 24'h00FF00;
    pos_p1 = 6'd1; pos_ball = 6'd1;
    pulse_start();
    wait_ld("t3");
    wait_fd("t3");
    chk("t3_led1_b0", hi[1][0], 3);
    chk("t3_led1_b8", hi[1][8], 6);
    chk("t3_led1_b15", hi[1][15], 6);
    chk("t3_led1_b23", hi[1][23], 3);
    chk("t3_led0_high", led_sum(0), 72);

    // 4: start and pos_ball change mid-frame are ignored
    colb = 24'hFF0000; pos_p1 = 6'd9; pos_ball = 6'd0;
    base_ld = n_ld; base_fd = n_fd;
    pulse_start();
    wait_ld("t4");
    repeat (300) @(posedge clk);
    #1 start = 1'b1; pos_ball = 6'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_fd("t4");
    repeat (30) @(posedge clk);
    #1;
    chk("t4_loads", n_ld - base_ld, 1);
    chk("t4_frame_dones", n_fd - base_fd, 1);
    chk("t4_led0_b0", hi[0][0], 6);
    chk("t4_led3_b0", hi[3][0], 3);

    // 5: reset during LED2 bit 5
    pos_ball = 6'd2;
    base_fd = n_fd;
    pulse_start();
    wait_ld("t5");
    repeat (533) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t5_busy_after_reset", int'(busy), 0);
    chk("t5_dout_after_reset", int'(dout), 0);
    repeat (40) @(posedge clk);
    #1;
    chk("t5_no_frame_done", n_fd - base_fd, 0);
    pulse_start();
    wait_ld("t5b");
    wait_fd("t5b");
    chk("t5_fd_offset", fd_t, 980);
    chk("t5_led2_b0", hi[2][0], 6);
    chk("t5_led2_high", led_sum(2), 96);

    // 6: start held high, three back-to-back frames
    base_ld = n_ld;
    @(posedge clk); #1 start = 1'b1;
    wait_ld("t6a");
    wait_fd("t6a");
    s1 = sig_last;
    wait_ld("t6b");
    chk("t6_gap_ab", gap, 2);
    wait_fd("t6b");
    s2 = sig_last;
    wait_ld("t6c");
    chk("t6_gap_bc", gap, 2);
    @(posedge clk); #1 start = 1'b0;
    wait_fd("t6c");
    s3 = sig_last;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_loads", n_ld - base_ld, 3);
    chk("t6_frame2_same", s2, s1);
    chk("t6_frame3_same", s3, s1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
